// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and receiver state encoding.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous input; resets to 1 (idle-high line).
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nReset,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_en.sv
// Enable-gated 8N1 UART receiver; en ticks at OVERSAMPLE x baud, bits sampled mid-period.
module uart_rx_en
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 en,
    input  logic                 in,
    output logic [DATA_BITS-1:0] data,
    output logic                 done,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

    logic rxd;

    rx_state_e            state_q, state_d;
    logic [SW-1:0]        sample_q, sample_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 armed_q, armed_d;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .nReset (nReset),
        .async_i(in),
        .sync_o (rxd)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= IDLE;
            sample_q <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            armed_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            done_q   <= done_d;
            err_q    <= err_d;
            armed_q  <= armed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        done_d   = 1'b0;
        err_d    = err_q;
        armed_d  = armed_q;

        if (en) begin
            unique case (state_q)
                IDLE: begin
                    // armed blocks a held-low (break) line from re-triggering frames
                    if (rxd) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d  = START;
                        sample_d = '0;
                    end
                end
                START: begin
                    if (sample_q == HALF_LAST) begin
                        if (!rxd) begin
                            state_d  = DATA;
                            sample_d = '0;
                            bit_d    = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sample_d = sample_q + SW'(1);
                    end
                end
                DATA: begin
                    if (sample_q == BIT_LAST) begin
                        shift_d  = {rxd, shift_q[DATA_BITS-1:1]};
                        bit_d    = bit_q + 4'd1;
                        sample_d = '0;
                        if (bit_q == LAST_BIT) begin
                            state_d = STOP;
                        end
                    end else begin
                        sample_d = sample_q + SW'(1);
                    end
                end
                STOP: begin
                    if (sample_q == BIT_LAST) begin
                        data_d   = shift_q;
                        done_d   = 1'b1;
                        err_d    = ~rxd;
                        state_d  = IDLE;
                        sample_d = '0;
                        if (!rxd) begin
                            armed_d = 1'b0;
                        end
                    end else begin
                        sample_d = sample_q + SW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign data = data_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = (state_q != IDLE);

endmodule
